// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and controller state type for the pipelined ALU.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DIV_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_div_seq.sv
// Restoring shift-subtract divider: one quotient bit per cycle, WIDTH cycles per
// division. done_o and quotient_o present the final iteration combinationally.
module alu_div_seq
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Bit WIDTH of diff set means the trial subtraction went negative: restore.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == LAST);
  assign quotient_o = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/alu_pipe.sv
// Registered 16-opcode ALU with valid/ready handshakes on both sides; DIV with a
// non-zero divisor runs on the sequential divider, everything else is one cycle.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             busy
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               zero_q, zero_d;

  logic [WIDTH:0]     fast_res;
  logic [2*WIDTH-1:0] prod;
  logic               is_div_run;
  logic               accept;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic               load;
  logic [WIDTH:0]     load_val;

  always_comb begin
    fast_res = '0;
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (alu_sel)
      OP_ADD:  fast_res = {1'b0, a} + {1'b0, b};
      OP_SUB:  fast_res = {1'b0, a} - {1'b0, b};
      OP_MUL:  fast_res = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      OP_DIV:  fast_res = {1'b1, {WIDTH{1'b1}}};
      OP_SHL:  fast_res = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_SHR:  fast_res = {a[0], 1'b0, a[WIDTH-1:1]};
      OP_ROL:  fast_res = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  fast_res = {1'b0, a[0], a[WIDTH-1:1]};
      OP_AND:  fast_res = {1'b0, a & b};
      OP_OR:   fast_res = {1'b0, a | b};
      OP_XOR:  fast_res = {1'b0, a ^ b};
      OP_NOR:  fast_res = {1'b0, ~(a | b)};
      OP_NAND: fast_res = {1'b0, ~(a & b)};
      OP_XNOR: fast_res = {1'b0, ~(a ^ b)};
      OP_GT:   fast_res = {{WIDTH{1'b0}}, (a > b)};
      OP_EQ:   fast_res = {{WIDTH{1'b0}}, (a == b)};
      default: fast_res = '0;
    endcase
  end

  assign is_div_run = (alu_sel == OP_DIV) && (b != '0);
  assign in_ready   = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign div_start  = accept && is_div_run;

  alu_div_seq #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (a),
    .divisor_i  (b),
    .busy_o     (busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // A new result may overwrite the register on the same edge the old one is taken.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    load        = 1'b0;
    load_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          state_d = ST_DIV_RUN;
        end else if (accept) begin
          load     = 1'b1;
          load_val = fast_res;
        end
      end
      ST_DIV_RUN: begin
        if (div_done) begin
          state_d  = ST_IDLE;
          load     = 1'b1;
          load_val = {1'b0, div_quo};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = load_val;
      zero_d      = (load_val[WIDTH-1:0] == '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_alu_pipe;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [7:0] aIn = '0;
  logic [7:0] bIn = '0;
  logic [3:0] selIn = '0;
  logic       outValid;
  logic       outReady = 1'b1;
  logic [8:0] result;
  logic       zero;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] res;
    int         due;
  } expEntry_t;

  expEntry_t expQ[$];
  int        cyc   = 0;
  bit        live  = 0;
  bit        fresh = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (aIn),
    .b         (bIn),
    .alu_sel   (selIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the opcode table, using plain integers.
  function automatic logic [8:0] refModel(input int a, input int b, input int sel);
    int r;
    int p;
    r = 0;
    p = a * b;
    case (sel)
      0:  r = a + b;
      1:  r = (a - b) & 511;
      2:  r = (p % 256) + ((p / 256 != 0) ? 256 : 0);
      3:  r = (b == 0) ? 511 : a / b;
      4:  r = ((a * 2) % 256) + ((a >= 128) ? 256 : 0);
      5:  r = (a / 2) + ((a % 2) * 256);
      6:  r = ((a * 2) % 256) + (a / 128);
      7:  r = (a / 2) + ((a % 2) * 128);
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = (~(a | b)) & 255;
      12: r = (~(a & b)) & 255;
      13: r = (~(a ^ b)) & 255;
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return r[8:0];
  endfunction

  function automatic bit expOutValid();
    return (expQ.size() > 0) && (expQ[0].due <= cyc);
  endfunction

  function automatic bit divInFlight();
    return (expQ.size() > 0) && (expQ[expQ.size()-1].due > cyc);
  endfunction

  function automatic bit expInReady();
    return !rst && !divInFlight() && (!expOutValid() || outReady);
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                               input logic [3:0] sv, input logic ordy);
    inValid  = v;
    aIn      = av;
    bIn      = bv;
    selIn    = sv;
    outReady = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update: every transfer the DUT should perform at this edge.
  always @(posedge clk) begin : modelUpdate
    bit        ov;
    bit        acc;
    expEntry_t e;
    if (rst) begin
      expQ.delete();
      live  = 1;
      fresh = 1;
    end else if (live) begin
      ov  = expOutValid();
      acc = inValid && expInReady();
      if (ov && outReady) void'(expQ.pop_front());
      if (acc) begin
        e.res = refModel(aIn, bIn, selIn);
        e.due = (selIn == 4'd3 && bIn != 8'd0) ? cyc + 1 + W : cyc + 1;
        expQ.push_back(e);
        fresh = 0;
      end
    end
    cyc++;
  end

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin : compare
    logic [8:0] expRes;
    if (live) begin
      checkOutput("out_valid", {8'b0, outValid}, {8'b0, expOutValid()});
      checkOutput("in_ready", {8'b0, inReady}, {8'b0, expInReady()});
      checkOutput("busy", {8'b0, busy}, {8'b0, divInFlight()});
      if (expOutValid()) begin
        expRes = expQ[0].res;
        checkOutput("result", result, expRes);
        checkOutput("zero", {8'b0, zero}, {8'b0, (expRes[7:0] == 8'd0)});
      end else if (fresh) begin
        checkOutput("result_after_reset", result, 9'h000);
      end
    end
  end

  initial begin
    // Pin the reference model with hand-computed values.
    checkOutput("model_add", refModel(255, 255, 0), 9'h1FE);
    checkOutput("model_sub", refModel(15, 240, 1), 9'h11F);
    checkOutput("model_mul", refModel(16, 16, 2), 9'h100);
    checkOutput("model_div", refModel(200, 7, 3), 9'd28);
    checkOutput("model_div0", refModel(5, 0, 3), 9'h1FF);
    checkOutput("model_rol", refModel(8'h81, 0, 6), 9'h003);
    checkOutput("model_shr", refModel(8'h03, 0, 5), 9'h101);
    checkOutput("model_eq", refModel(9, 9, 15), 9'h001);

    // Reset held two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", {8'b0, outValid}, 9'h000);
    checkOutput("reset_result", result, 9'h000);
    checkOutput("reset_busy", {8'b0, busy}, 9'h000);
    checkOutput("reset_in_ready", {8'b0, inReady}, 9'h001);

    // Single-cycle ops.
    applyStimulus(1'b1, 8'd255, 8'd255, 4'd0, 1'b1);
    tick();
    checkOutput("add_valid", {8'b0, outValid}, 9'h001);
    checkOutput("add_result", result, 9'h1FE);
    checkOutput("add_zero", {8'b0, zero}, 9'h000);
    applyStimulus(1'b1, 8'd15, 8'd240, 4'd1, 1'b1);
    tick();
    checkOutput("sub_result", result, 9'h11F);
    applyStimulus(1'b1, 8'd16, 8'd16, 4'd2, 1'b1);
    tick();
    checkOutput("mul_result", result, 9'h100);
    checkOutput("mul_zero", {8'b0, zero}, 9'h001);

    // Multi-cycle division.
    applyStimulus(1'b1, 8'd200, 8'd7, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
    #1;
    checkOutput("div_busy_0", {8'b0, busy}, 9'h001);
    checkOutput("div_in_ready", {8'b0, inReady}, 9'h000);
    for (int i = 1; i < W; i++) begin
      tick();
      checkOutput("div_busy", {8'b0, busy}, 9'h001);
      checkOutput("div_not_valid", {8'b0, outValid}, 9'h000);
    end
    tick();
    checkOutput("div_done_busy", {8'b0, busy}, 9'h000);
    checkOutput("div_valid", {8'b0, outValid}, 9'h001);
    checkOutput("div_result", result, 9'd28);

    applyStimulus(1'b1, 8'd5, 8'd0, 4'd3, 1'b1);
    tick();
    checkOutput("div0_valid", {8'b0, outValid}, 9'h001);
    checkOutput("div0_result", result, 9'h1FF);
    checkOutput("div0_busy", {8'b0, busy}, 9'h000);
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
    tick();

    // Output hold under backpressure, then accept with no bubble.
    applyStimulus(1'b1, 8'd1, 8'd2, 4'd0, 1'b0);
    tick();
    checkOutput("hold_result_first", result, 9'd3);
    applyStimulus(1'b1, 8'd4, 8'd8, 4'd9, 1'b0);
    #1;
    checkOutput("hold_in_ready", {8'b0, inReady}, 9'h000);
    tick();
    tick();
    checkOutput("hold_valid", {8'b0, outValid}, 9'h001);
    checkOutput("hold_result", result, 9'd3);
    applyStimulus(1'b1, 8'd4, 8'd8, 4'd9, 1'b1);
    #1;
    checkOutput("release_in_ready", {8'b0, inReady}, 9'h001);
    tick();
    checkOutput("nobubble_valid", {8'b0, outValid}, 9'h001);
    checkOutput("nobubble_result", result, 9'h00C);
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
    tick();
    checkOutput("drain_valid", {8'b0, outValid}, 9'h000);

    // Reset during a division.
    applyStimulus(1'b1, 8'd200, 8'd7, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", {8'b0, busy}, 9'h000);
    checkOutput("abort_valid", {8'b0, outValid}, 9'h000);
    checkOutput("abort_result", result, 9'h000);
    rst = 1'b0;
    applyStimulus(1'b1, 8'd9, 8'd9, 4'd15, 1'b1);
    tick();
    checkOutput("eq_result", result, 9'h001);
    checkOutput("eq_valid", {8'b0, outValid}, 9'h001);

    // Randomized traffic, including backpressure, zero divisors and rare resets.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      inValid  = ($urandom_range(0, 9) < 7);
      aIn      = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      bIn      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      selIn    = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom);
      outReady = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
    repeat (W + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
